// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared writeback-stage types, funct3 load encodings and result select helper.

package pipeline_pkg;

  localparam int XLEN    = 64;
  localparam int REG_AW  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } wb_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // Link beats load beats ALU: JAL/JALR never have mem_to_reg set, but the order is fixed regardless.
  function automatic logic [XLEN-1:0] select_wdata(
    input logic            link,
    input logic            mem_to_reg,
    input logic [XLEN-1:0] pc_plus4,
    input logic [XLEN-1:0] load_result,
    input logic [XLEN-1:0] alu_data
  );
    if (link) begin
      return pc_plus4;
    end else if (mem_to_reg) begin
      return load_result;
    end else begin
      return alu_data;
    end
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - shifts a cache doubleword to the load byte offset and sign/zero extends by funct3.

module load_align
  import pipeline_pkg::*;
(
  input  logic [XLEN-1:0] loaded_data,
  input  logic [2:0]      addr_low,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  // Logical shift: bytes past the top of the doubleword come back as zero on misaligned access.
  assign shifted = loaded_data >> {addr_low, 3'b000};

  always_comb begin
    result = '0;
    case (funct3)
      LB:      result = {{56{shifted[7]}},  shifted[7:0]};
      LH:      result = {{48{shifted[15]}}, shifted[15:0]};
      LW:      result = {{32{shifted[31]}}, shifted[31:0]};
      LD:      result = shifted;
      LBU:     result = {56'd0, shifted[7:0]};
      LHU:     result = {48'd0, shifted[15:0]};
      LWU:     result = {32'd0, shifted[31:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB capture, register-file write, scoreboard release and retire counter.
// Optional WB_FORWARD_EN adds the fwd_valid/fwd_rd/fwd_data bypass outputs.

module writeback_stage
  import pipeline_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              memory_done,
  input  logic [XLEN-1:0]   loaded_data,
  input  logic [XLEN-1:0]   alu_data,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              link,
  input  logic [2:0]        funct3,
  output logic              mem_wb_pipeline_valid,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              scoreboard_clr,
  output logic [REG_AW-1:0] scoreboard_rd,
  output logic [XLEN-1:0]   retire_count
`ifdef WB_FORWARD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data
`endif
);

  wb_state_t         state_q, state_d;
  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic              clr_q, clr_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   retire_q, retire_d;
  logic [XLEN-1:0]   load_result;

  load_align u_load_align (
    .loaded_data (loaded_data),
    .addr_low    (alu_data[2:0]),
    .funct3      (funct3),
    .result      (load_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      clr_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      clr_q    <= clr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      retire_q <= retire_d;
    end
  end

  // Outputs are computed for the state being entered, so every port comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    we_d     = 1'b0;
    clr_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    retire_d = retire_q;
    case (state_q)
      IDLE: begin
        if (memory_done) begin
          state_d  = WRITE;
          valid_d  = 1'b1;
          we_d     = reg_write && (rd != '0);
          clr_d    = reg_write;
          waddr_d  = rd;
          wdata_d  = select_wdata(link, mem_to_reg, pc_plus4, load_result, alu_data);
          retire_d = retire_q + 64'd1;
        end
      end
      WRITE, HOLD: begin
        // memory_done still high means the producer has not yet seen the ack; park without recapturing.
        if (memory_done) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_wb_pipeline_valid = valid_q;
  assign rf_we                 = we_q;
  assign rf_waddr              = waddr_q;
  assign rf_wdata              = wdata_q;
  assign scoreboard_clr        = clr_q;
  assign scoreboard_rd         = waddr_q;
  assign retire_count          = retire_q;

`ifdef WB_FORWARD_EN
  logic fwd_valid_q, fwd_valid_d;

  always_comb begin
    fwd_valid_d = 1'b0;
    case (state_q)
      IDLE:        fwd_valid_d = memory_done && reg_write && (rd != '0);
      WRITE, HOLD: fwd_valid_d = memory_done && fwd_valid_q;
      default:     fwd_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_valid_q <= 1'b0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_rd    = waddr_q;
  assign fwd_data  = wdata_q;
`endif

endmodule
